interface_input_pipe: RTL and testbench

Registered, parametrised front end of the CORDIC core. It accepts one sample per handshake: signed angle plus signed x/y, with a mode bit. It folds the sample into the first-quadrant working range and emits it with a sector tag for the iteration stages. Compared with the combinational front end it adds:
- a two-stage valid/ready pipeline with backpressure;
- fixed-point angles with wrap-around of ±360°;
- quadrant folding of x/y in arctan (vectoring) mode;
- a sideband tag and a range-error flag.

---
 rtl/chord_pkg.sv | 23 ++
 rtl/pipe_stage_ctrl.sv | 26 ++
 rtl/interface_input_pipe.sv | 183 ++++++++++++++++++
 tb/tb_interface_input_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chord_pkg.sv
// rtl/chord_pkg.sv - shared CORDIC sector codes, angle constants and helpers
package chord_pkg;

  localparam logic [1:0] S1 = 2'b00;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;
  localparam logic [1:0] S4 = 2'b01;

  // Whole degrees expressed as a fixed-point angle with frac fractional bits.
  function automatic longint deg_fx(input int deg, input int frac);
    return longint'(deg) <<< frac;
  endfunction

  // Two's-complement negate of a width-bit value; the most-negative code maps to +max.
  function automatic longint sat_neg(input longint v, input int width);
    longint lo;
    longint hi;
    lo = -(64'sd1 <<< (width - 1));
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    return (v == lo) ? hi : -v;
  endfunction

endpackage

// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - valid/ready bookkeeping for one register stage
module pipe_stage_ctrl (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_up_valid,
  input  logic i_next_advance,
  output logic o_valid,
  output logic o_load,
  output logic o_accept
);

  logic r_valid;

  assign o_load   = !r_valid | i_next_advance;
  assign o_accept = o_load & i_up_valid;
  assign o_valid  = r_valid;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
    end else if (o_load) begin
      r_valid <= i_up_valid;
    end
  end

endmodule

// File: rtl/interface_input_pipe.sv
// rtl/interface_input_pipe.sv - CORDIC front end: angle wrap, quadrant fold, 2-stage handshake
module interface_input_pipe
  import chord_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int ANGLE_WIDTH       = 20,
  parameter int ANGLE_FRAC_WIDTH  = 8,
  parameter int TAG_WIDTH         = 4,
  parameter int SECTOR_FLAG_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_arctan_en,
  input  logic signed [ANGLE_WIDTH-1:0] in_degree,
  input  logic signed [DATA_WIDTH-1:0]  in_x,
  input  logic signed [DATA_WIDTH-1:0]  in_y,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_arctan_en,
  output logic signed [ANGLE_WIDTH-1:0] out_degree,
  output logic signed [DATA_WIDTH-1:0]  out_x,
  output logic signed [DATA_WIDTH-1:0]  out_y,
  output logic [SECTOR_FLAG_WIDTH-1:0]  out_sector,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic                          out_range_err
);

  localparam int AW1 = ANGLE_WIDTH + 1;
  localparam logic signed [AW1-1:0] D90    = AW1'(deg_fx(90, ANGLE_FRAC_WIDTH));
  localparam logic signed [AW1-1:0] D180   = AW1'(deg_fx(180, ANGLE_FRAC_WIDTH));
  localparam logic signed [AW1-1:0] D360   = AW1'(deg_fx(360, ANGLE_FRAC_WIDTH));
  localparam logic signed [AW1-1:0] N_D90  = -D90;
  localparam logic signed [AW1-1:0] N_D180 = -D180;
  localparam logic signed [AW1-1:0] N_D360 = -D360;
  localparam logic signed [AW1-1:0] ZERO   = '0;

  if (ANGLE_WIDTH < $clog2(deg_fx(360, ANGLE_FRAC_WIDTH)) + 1) begin : g_angle_width_check
    $error("ANGLE_WIDTH cannot represent +/-360 degrees");
  end

  logic w_s1_valid, w_s1_load, w_s1_accept;
  logic w_s2_load, w_s2_accept;

  pipe_stage_ctrl u_s1_ctrl (
    .clk            (clk),
    .i_rst_n        (rst),
    .i_up_valid     (in_valid),
    .i_next_advance (w_s2_load),
    .o_valid        (w_s1_valid),
    .o_load         (w_s1_load),
    .o_accept       (w_s1_accept)
  );

  pipe_stage_ctrl u_s2_ctrl (
    .clk            (clk),
    .i_rst_n        (rst),
    .i_up_valid     (w_s1_valid),
    .i_next_advance (out_valid & out_ready),
    .o_valid        (out_valid),
    .o_load         (w_s2_load),
    .o_accept       (w_s2_accept)
  );

  assign in_ready = w_s1_load;

  // Stage 1: single wrap into (-180, +180]; out-of-range inputs are flagged, not clamped.
  logic signed [AW1-1:0]         w_d_ext;
  logic signed [ANGLE_WIDTH-1:0] w_d_wrap;
  logic                          w_range_err;

  assign w_d_ext     = {in_degree[ANGLE_WIDTH-1], in_degree};
  assign w_range_err = (w_d_ext >= D360) || (w_d_ext <= N_D360);

  always_comb begin
    w_d_wrap = ANGLE_WIDTH'(w_d_ext);
    if (w_d_ext > D180) begin
      w_d_wrap = ANGLE_WIDTH'(w_d_ext - D360);
    end else if (w_d_ext <= N_D180) begin
      w_d_wrap = ANGLE_WIDTH'(w_d_ext + D360);
    end
  end

  logic                          r1_arctan;
  logic signed [ANGLE_WIDTH-1:0] r1_degree;
  logic signed [DATA_WIDTH-1:0]  r1_x;
  logic signed [DATA_WIDTH-1:0]  r1_y;
  logic [TAG_WIDTH-1:0]          r1_tag;
  logic                          r1_range_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_arctan    <= 1'b0;
      r1_degree    <= '0;
      r1_x         <= '0;
      r1_y         <= '0;
      r1_tag       <= '0;
      r1_range_err <= 1'b0;
    end else if (w_s1_accept) begin
      r1_arctan    <= in_arctan_en;
      r1_degree    <= w_d_wrap;
      r1_x         <= in_x;
      r1_y         <= in_y;
      r1_tag       <= in_tag;
      r1_range_err <= w_range_err;
    end
  end

  // Stage 2: fold into the first quadrant, by angle in rotation mode or by x/y signs in arctan mode.
  logic signed [AW1-1:0]         w_n;
  logic signed [DATA_WIDTH-1:0]  w_neg_x, w_neg_y;
  logic [SECTOR_FLAG_WIDTH-1:0]  w_sector;
  logic signed [ANGLE_WIDTH-1:0] w_deg;
  logic signed [DATA_WIDTH-1:0]  w_x, w_y;

  assign w_n     = {r1_degree[ANGLE_WIDTH-1], r1_degree};
  assign w_neg_x = DATA_WIDTH'(sat_neg(longint'(r1_x), DATA_WIDTH));
  assign w_neg_y = DATA_WIDTH'(sat_neg(longint'(r1_y), DATA_WIDTH));

  always_comb begin
    w_sector = SECTOR_FLAG_WIDTH'(S1);
    w_deg    = '0;
    w_x      = r1_x;
    w_y      = r1_y;
    if (r1_arctan) begin
      case ({r1_x[DATA_WIDTH-1], r1_y[DATA_WIDTH-1]})
        2'b00: begin
          w_sector = SECTOR_FLAG_WIDTH'(S1);
        end
        2'b10: begin
          w_sector = SECTOR_FLAG_WIDTH'(S2);
          w_x      = r1_y;
          w_y      = w_neg_x;
        end
        2'b11: begin
          w_sector = SECTOR_FLAG_WIDTH'(S3);
          w_x      = w_neg_x;
          w_y      = w_neg_y;
        end
        default: begin
          w_sector = SECTOR_FLAG_WIDTH'(S4);
          w_x      = w_neg_y;
          w_y      = r1_x;
        end
      endcase
    end else if (w_n >= D90) begin
      w_sector = SECTOR_FLAG_WIDTH'(S2);
      w_deg    = ANGLE_WIDTH'(w_n - D90);
    end else if (w_n > ZERO) begin
      w_sector = SECTOR_FLAG_WIDTH'(S1);
      w_deg    = ANGLE_WIDTH'(w_n);
    end else if (w_n <= N_D90) begin
      w_sector = SECTOR_FLAG_WIDTH'(S3);
      w_deg    = ANGLE_WIDTH'(w_n + D180);
    end else begin
      w_sector = SECTOR_FLAG_WIDTH'(S4);
      w_deg    = ANGLE_WIDTH'(w_n + D90);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_arctan_en <= 1'b0;
      out_degree    <= '0;
      out_x         <= '0;
      out_y         <= '0;
      out_sector    <= '0;
      out_tag       <= '0;
      out_range_err <= 1'b0;
    end else if (w_s2_accept) begin
      out_arctan_en <= r1_arctan;
      out_degree    <= w_deg;
      out_x         <= w_x;
      out_y         <= w_y;
      out_sector    <= w_sector;
      out_tag       <= r1_tag;
      out_range_err <= r1_range_err;
    end
  end

endmodule

// File: tb/tb_interface_input_pipe.sv
// tb/tb_interface_input_pipe.sv - directed and scoreboarded bench for interface_input_pipe
module tb_interface_input_pipe;

  localparam int DW = 16;
  localparam int AW = 20;
  localparam int TW = 4;
  localparam int SW = 2;
  localparam int DEG = 256;

  logic          clk;
  logic          rst;
  logic          in_valid, in_ready, in_arctan_en;
  logic [AW-1:0] in_degree;
  logic [DW-1:0] in_x, in_y;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready, out_arctan_en, out_range_err;
  logic [AW-1:0] out_degree;
  logic [DW-1:0] out_x, out_y;
  logic [SW-1:0] out_sector;
  logic [TW-1:0] out_tag;

  interface_input_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_arctan_en  (in_arctan_en),
    .in_degree     (in_degree),
    .in_x          (in_x),
    .in_y          (in_y),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_arctan_en (out_arctan_en),
    .out_degree    (out_degree),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_sector    (out_sector),
    .out_tag       (out_tag),
    .out_range_err (out_range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [TW-1:0] vtag = '0;

  typedef struct packed {
    logic [1:0]    sec;
    logic [AW-1:0] deg;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [TW-1:0] tag;
    logic          err;
    logic          mode;
  } exp_t;

  exp_t q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sneg(input int v);
    return (v == -32768) ? 32767 : -v;
  endfunction

  function automatic exp_t model(input logic mode, input int d, input int x, input int y,
                                 input logic [TW-1:0] tag);
    exp_t e;
    int n, ox, oy, od;
    logic [1:0] s;
    n  = d;
    ox = x;
    oy = y;
    od = 0;
    if (n > 180 * DEG) n = n - 360 * DEG;
    else if (n <= -180 * DEG) n = n + 360 * DEG;
    if (mode) begin
      if (x >= 0 && y >= 0) s = 2'b00;
      else if (x < 0 && y >= 0) begin s = 2'b10; ox = y; oy = sneg(x); end
      else if (x < 0) begin s = 2'b11; ox = sneg(x); oy = sneg(y); end
      else begin s = 2'b01; ox = sneg(y); oy = x; end
    end else if (n >= 90 * DEG) begin s = 2'b10; od = n - 90 * DEG; end
    else if (n > 0) begin s = 2'b00; od = n; end
    else if (n <= -90 * DEG) begin s = 2'b11; od = n + 180 * DEG; end
    else begin s = 2'b01; od = n + 90 * DEG; end
    e.sec  = s;
    e.deg  = AW'(od);
    e.x    = DW'(ox);
    e.y    = DW'(oy);
    e.tag  = tag;
    e.err  = (d >= 360 * DEG) || (d <= -360 * DEG);
    e.mode = mode;
    return e;
  endfunction

  task automatic run_vec(input string tag, input logic mode, input int d, input int x, input int y,
                         input logic [1:0] es, input int ed, input int ex, input int ey,
                         input logic ee);
    int w;
    logic [AW-1:0] ed_b;
    logic [DW-1:0] ex_b, ey_b;
    ed_b = AW'(ed);
    ex_b = DW'(ex);
    ey_b = DW'(ey);
    in_arctan_en = mode;
    in_degree    = AW'(d);
    in_x         = DW'(x);
    in_y         = DW'(y);
    in_tag       = vtag;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, "_lat"}, 64'(w), 64'd1);
    check({tag, "_err"}, out_range_err, ee);
    check({tag, "_tag"}, out_tag, vtag);
    check({tag, "_mode"}, out_arctan_en, mode);
    if (!ee) begin
      check({tag, "_sec"}, out_sector, es);
      check({tag, "_deg"}, out_degree, ed_b);
    end
    check({tag, "_x"}, out_x, ex_b);
    check({tag, "_y"}, out_y, ey_b);
    @(posedge clk); #1;
    vtag++;
  endtask

  int bnd[11] = '{0, 23040, -23040, 46080, -46080, 92160, -92160, 91904, -91904, 1, -1};

  initial begin
    #900_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent, got, cyc, stray, hits, tag_bad, cur_d, cur_x, cur_y;
    logic cur_m, acc;
    exp_t e, g;

    rst = 1'b0; in_valid = 1'b0; in_arctan_en = 1'b0; in_degree = '0;
    in_x = '0; in_y = '0; in_tag = '0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sector", out_sector, 0);
    check("rst_degree", out_degree, 0);
    check("rst_tag", out_tag, 0);
    check("rst_err", out_range_err, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // rotation sweep and boundaries
    run_vec("r45",   0, 45 * DEG,   100, -200, 2'b00, 11520, 100, -200, 0);
    run_vec("r135",  0, 135 * DEG,  7, 9,      2'b10, 11520, 7, 9, 0);
    run_vec("rm135", 0, -135 * DEG, 7, 9,      2'b11, 11520, 7, 9, 0);
    run_vec("rm45",  0, -45 * DEG,  7, 9,      2'b01, 11520, 7, 9, 0);
    run_vec("r90",   0, 90 * DEG,   1, 2,      2'b10, 0, 1, 2, 0);
    run_vec("r0",    0, 0,          1, 2,      2'b01, 23040, 1, 2, 0);
    run_vec("rm90",  0, -90 * DEG,  1, 2,      2'b11, 23040, 1, 2, 0);
    run_vec("r180",  0, 180 * DEG,  1, 2,      2'b10, 23040, 1, 2, 0);
    run_vec("rm180", 0, -180 * DEG, 1, 2,      2'b10, 23040, 1, 2, 0);
    run_vec("rlsb",  0, 1,          1, 2,      2'b00, 1, 1, 2, 0);
    run_vec("r270",  0, 270 * DEG,  1, 2,      2'b11, 23040, 1, 2, 0);
    run_vec("r359",  0, 359 * DEG,  1, 2,      2'b01, 22784, 1, 2, 0);
    run_vec("r360",  0, 360 * DEG,  1, 2,      2'b00, 0, 1, 2, 1);
    run_vec("rm360", 0, -360 * DEG, 1, 2,      2'b00, 0, 1, 2, 1);
    // arctan folding, including saturation
    run_vec("a_q2",  1, 12345, -3, 5,      2'b10, 0, 5, 3, 0);
    run_vec("a_q3",  1, 12345, -3, -5,     2'b11, 0, 3, 5, 0);
    run_vec("a_sat", 1, 0,     -32768, 1,  2'b10, 0, 1, 32767, 0);
    run_vec("a_q1",  1, 0,     3, 5,       2'b00, 0, 3, 5, 0);
    run_vec("a_q4",  1, 0,     3, -5,      2'b01, 0, 5, 3, 0);
    run_vec("a_q4s", 1, 0,     0, -32768,  2'b01, 0, 32767, 0, 0);

    // stall fill, combinational release, then reset with two samples in flight
    out_ready = 1'b0;
    in_valid = 1'b1; in_arctan_en = 1'b0; in_degree = AW'(11520); in_x = 16'd5; in_y = 16'd6;
    in_tag = 4'hA;
    @(posedge clk); #1;
    in_tag = 4'hB;
    @(posedge clk); #1;
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    in_tag = 4'hC;
    @(posedge clk); #1;
    check("stall_hold_tag", out_tag, 4'hA);
    check("stall_hold_ready", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1 check("release_in_ready", in_ready, 1);
    out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    stray = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) stray++;
    end
    check("rst_no_stale", 64'(stray), 0);

    // random backpressure against the reference model
    sent = 0; got = 0; cyc = 0;
    cur_d = 0; cur_x = 0; cur_y = 0; cur_m = 1'b0;
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      if (!in_valid && sent < 1000) begin
        cur_m = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) cur_d = bnd[$urandom_range(0, 10)];
        else cur_d = int'($urandom_range(0, 186000)) - 93000;
        cur_x = int'($urandom_range(0, 65535)) - 32768;
        cur_y = int'($urandom_range(0, 65535)) - 32768;
        in_arctan_en = cur_m; in_degree = AW'(cur_d);
        in_x = DW'(cur_x); in_y = DW'(cur_y); in_tag = vtag;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("bp_extra_output", 1, 0);
        end else begin
          e = q.pop_front();
          g = '{sec: out_sector, deg: out_degree, x: out_x, y: out_y,
                tag: out_tag, err: out_range_err, mode: out_arctan_en};
          if (e.err && !e.mode) begin
            e.sec = '0; e.deg = '0; g.sec = '0; g.deg = '0;
          end
          check("bp_sample", g, e);
          got++;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(model(cur_m, cur_d, cur_x, cur_y, vtag));
        sent++;
        vtag++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    check("bp_count", 64'(got), 1000);
    check("bp_drain", 64'(q.size()), 0);

    // full-rate run
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    hits = 0; stray = 0; tag_bad = 0;
    for (int c = 0; c < 105; c++) begin
      if (c < 100) begin
        in_valid = 1'b1; in_arctan_en = 1'b0; in_degree = AW'(c * 300);
        in_x = DW'(c); in_y = DW'(c); in_tag = TW'(c);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        if (c >= 2 && c <= 101) begin
          hits++;
          if (out_tag != TW'(c - 2)) tag_bad++;
        end else begin
          stray++;
        end
      end
      if (c < 100 && !in_ready) stray++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("fr_window", 64'(hits), 100);
    check("fr_outside", 64'(stray), 0);
    check("fr_tag_order", 64'(tag_bad), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
